// File: rtl/inst_sequencer.sv
// Program buffer that is filled over a valid/ready port and replayed one instruction per cycle onto the S-Machine CPU.
// Optional PC divergence check is enabled by defining INST_SEQ_PC_CHECK_EN.
module inst_sequencer #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       load_valid,
    input  logic [INST_W-1:0]          load_inst,
    output logic                       load_ready,
    input  logic                       start,
    input  logic                       loop_mode,
    input  logic                       stall,
    input  logic                       abort,
    output logic [INST_W-1:0]          inst,
    output logic                       enable,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           issue_count,
    output logic [CNT_W-1:0]           loop_count,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    input  logic [ADDR_W-1:0]          pc_in,
    output logic                       pc_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      buf_count_q, buf_count_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic               enable_q, enable_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   issue_count_q, issue_count_d;
    logic [CNT_W-1:0]   loop_count_q, loop_count_d;
    logic               loop_mode_q, loop_mode_d;
    logic               pc_error_q, pc_error_d;
    logic               wr_en;
    logic               pc_mismatch;
    logic [INST_W-1:0]  mem_q [DEPTH];

`ifdef INST_SEQ_PC_CHECK_EN
    // The CPU PC should equal the issue count one cycle after each issue.
    logic              chk_q;
    logic [ADDR_W-1:0] exp_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q    <= 1'b0;
            exp_pc_q <= '0;
        end else begin
            chk_q    <= enable_q;
            exp_pc_q <= ADDR_W'(issue_count_q);
        end
    end

    assign pc_mismatch = chk_q && (pc_in != exp_pc_q);
`else
    logic unused_pc;
    assign unused_pc   = ^pc_in;
    assign pc_mismatch = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        buf_count_d   = buf_count_q;
        inst_d        = inst_q;
        enable_d      = 1'b0;
        done_d        = 1'b0;
        issue_count_d = issue_count_q;
        loop_count_d  = loop_count_q;
        loop_mode_d   = loop_mode_q;
        pc_error_d    = pc_error_q | pc_mismatch;
        wr_en         = 1'b0;
        load_ready    = (state_q == S_IDLE) && (buf_count_q < CW'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    wr_ptr_d    = '0;
                    buf_count_d = '0;
                end else if (load_valid && load_ready) begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    buf_count_d = buf_count_q + CW'(1);
                end
                // A simultaneous clear empties the buffer, so it also cancels the start.
                if (start && !clear && buf_count_q != '0) begin
                    state_d       = S_RUN;
                    rd_ptr_d      = '0;
                    issue_count_d = '0;
                    loop_count_d  = '0;
                    pc_error_d    = 1'b0;
                    loop_mode_d   = loop_mode;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    rd_ptr_d = '0;
                end else if (!stall) begin
                    inst_d        = mem_q[rd_ptr_q];
                    enable_d      = 1'b1;
                    issue_count_d = issue_count_q + CNT_W'(1);
                    if (CW'(rd_ptr_q) == buf_count_q - CW'(1)) begin
                        rd_ptr_d = '0;
                        if (loop_mode_q) begin
                            loop_count_d = loop_count_q + CNT_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rd_ptr_d = '0;
                done_d   = !abort;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            buf_count_q   <= '0;
            inst_q        <= '0;
            enable_q      <= 1'b0;
            done_q        <= 1'b0;
            issue_count_q <= '0;
            loop_count_q  <= '0;
            loop_mode_q   <= 1'b0;
            pc_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            buf_count_q   <= buf_count_d;
            inst_q        <= inst_d;
            enable_q      <= enable_d;
            done_q        <= done_d;
            issue_count_q <= issue_count_d;
            loop_count_q  <= loop_count_d;
            loop_mode_q   <= loop_mode_d;
            pc_error_q    <= pc_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= load_inst;
        end
    end

    assign inst        = inst_q;
    assign enable      = enable_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign issue_count = issue_count_q;
    assign loop_count  = loop_count_q;
    assign buf_count   = buf_count_q;
    assign pc_error    = pc_error_q;

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Synthesizable, parametrised instruction issuer for the S-Machine CPU; successor to hand-timed instruction stimulus.
- Program buffer of DEPTH entries, filled through a valid/ready load port, then replayed onto the CPU `inst`/`enable` inputs one instruction per cycle.
- Supports one-shot and loop replay, stall, abort and issue counting.
- Optional PC tracking flags CPU program-counter divergence.

Parameters:
- INST_W, 16, instruction width.
- ADDR_W, 8, CPU PC width.
- DEPTH, 16, program buffer entries; must be at least 2.
- CNT_W, 8, issue counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  empties the program buffer; honoured in IDLE only.
- load_valid  in  1  load data valid.
- load_inst  in  INST_W  instruction to append to the buffer.
- load_ready  out  1  buffer can accept an entry.
- start  in  1  begin replay; single-cycle pulse.
- loop_mode  in  1  sampled at start; 1 means wrap and repeat.
- stall  in  1  hold issue this cycle.
- abort  in  1  terminate replay.
- inst  out  INST_W  instruction driven to the CPU.
- enable  out  1  CPU enable; high on cycles that issue.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at normal completion.
- issue_count  out  CNT_W  instructions issued since the last start.
- loop_count  out  CNT_W  completed passes in loop mode.
- buf_count  out  clog2(DEPTH+1)  valid buffer entries.
- pc_in  in  ADDR_W  CPU PC; used only with the optional feature.
- pc_error  out  1  sticky PC mismatch flag.

Behaviour:
- Reset values: state=IDLE; all of the following are 0: buffer count, wr_ptr, rd_ptr, inst, enable, busy, done, issue_count, loop_count, pc_error. load_ready=1.
- Buffer contents are not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - load_ready = (buf_count < DEPTH).
  - A write occurs when load_valid && load_ready: buf[wr_ptr] <= load_inst, wr_ptr++, buf_count++.
  - clear has priority over a write in the same cycle: wr_ptr=0 and buf_count=0.
  - start with buf_count>0: go to RUN; rd_ptr=0, issue_count=0, loop_count=0, pc_error=0, loop_mode latched.
  - start with buf_count==0: ignored, stay in IDLE.
- RUN:
  - load_ready=0; load_valid and clear are ignored.
  - Each cycle with stall=0: inst <= buf[rd_ptr], enable <= 1, issue_count++ (wraps modulo 2^CNT_W), rd_ptr++.
  - Latency: one cycle from entering RUN to the first enable=1.
  - stall=1: enable <= 0, inst holds its value, no pointer or counter changes.
  - Last entry issued (rd_ptr == buf_count-1), latched loop_mode=1: rd_ptr <= 0, loop_count++, stay in RUN.
  - Last entry issued, latched loop_mode=0: go to DONE.
  - abort (from RUN or DONE): next cycle enable=0 and go to IDLE; done is not asserted. abort has priority over stall and over issue.
- DONE: enable=0, done=1 for exactly one cycle, then IDLE. rd_ptr returns to 0; buffer contents and buf_count are preserved for replay.
- start while in RUN or DONE: ignored.
- busy=1 exactly while state==RUN.
- rst during RUN: immediate return to reset values on the next edge; no done pulse.
- A buffer of size 1 in loop mode reissues the same entry every non-stalled cycle.

Optional Feature:
- Macro: INST_SEQ_PC_CHECK_EN.
- Defined:
  - One cycle after each issuing cycle, compare pc_in with the low ADDR_W bits of issue_count.
  - On inequality, pc_error <= 1; it stays set until the next accepted start or rst.
  - Comparison is skipped on cycles that follow a stall or non-issuing cycle.
- Undefined: pc_in is ignored and pc_error is tied to 0.

Test Plan:
- Load 0x0401, 0x0C01, 0x4000, 0x5000; start with loop_mode=0 -> buf_count=4; enable high for 4 consecutive cycles with inst=0x0401, 0x0C01, 0x4000, 0x5000 in that order; done pulse one cycle later; issue_count=4.
- Load DEPTH+1 entries with load_valid held high -> load_ready drops after DEPTH writes; entry DEPTH+1 is not accepted; buf_count=DEPTH.
- 3-entry program, loop_mode=1, run 10 issue cycles, then abort -> inst sequence wraps (e0, e1, e2, e0, ...); loop_count=3; issue_count=10; no done; IDLE one cycle after abort.
- stall high for 2 cycles mid-run of a 4-entry program -> enable=0 and inst held during the stall; issue order unchanged; total enable-high cycles = 4.
- start with empty buffer, and clear asserted together with load_valid -> no transition to RUN; buf_count=0 after the clear.
- With INST_SEQ_PC_CHECK_EN defined, pc_in stuck at 0 after the first issue -> pc_error=1 one cycle after that issue; stays 1 until the next start.
